ui_click_ctrl: RTL and testbench



---
 rtl/ui_pkg.sv | 12 +
 rtl/ui_click_ctrl_click_qualifier.sv | 34 +++
 rtl/ui_click_ctrl.sv | 80 ++++++++
 tb/tb_ui_click_ctrl.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/ui_pkg.sv
// ui_pkg: screen encodings, lookup states, hit-map geometry and address helper shared by ui_click_ctrl
package ui_pkg;
  typedef enum logic [1:0] {SCR_MENU = 2'd0, SCR_GAME = 2'd1, SCR_OVER = 2'd2} screen_e;
  typedef enum logic [1:0] {LK_IDLE, LK_WAIT, LK_CAPT} lk_state_e;
  localparam logic [1:0] BTN_CODE = 2'd2;
  localparam int IMG_W = 320;
  localparam int IMG_H = 240;
  localparam int HIT_ADDR_W = 17;
  function automatic logic [HIT_ADDR_W-1:0] hit_addr(input logic [8:0] hx, input logic [8:0] hy);
    return HIT_ADDR_W'(hx) + HIT_ADDR_W'(hy) * HIT_ADDR_W'(IMG_W);
  endfunction
endpackage

// File: rtl/ui_click_ctrl_click_qualifier.sv
// click_qualifier: press/release on hovered button -> one-cycle start/return pulse; clk,rst,mouse_left,hover,sel_over,clr in; start_pulse,return_pulse out
module click_qualifier (
  input  logic clk,
  input  logic rst,
  input  logic mouse_left,
  input  logic hover,
  input  logic sel_over,
  input  logic clr,
  output logic start_pulse,
  output logic return_pulse
);
  logic prev_q, armed_q, armed_d, sp_q, rp_q, rise, fall, fire;
  always_comb begin
    rise = mouse_left & ~prev_q;
    fall = ~mouse_left & prev_q;
    fire = fall & armed_q & hover & ~clr;
    armed_d = clr ? 1'b0 : rise ? hover : fall ? 1'b0 : armed_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q  <= 1'b0;
      armed_q <= 1'b0;
      sp_q    <= 1'b0;
      rp_q    <= 1'b0;
    end else begin
      prev_q  <= mouse_left;
      armed_q <= armed_d;
      sp_q    <= fire & ~sel_over;
      rp_q    <= fire & sel_over;
    end
  end
  assign start_pulse  = sp_q;
  assign return_pulse = rp_q;
endmodule

// File: rtl/ui_click_ctrl.sv
// ui_click_ctrl: hit-map lookup sequencer + MENU/GAME/OVER screen FSM; mouse/game_over/rom data in; rom_addr, screen, hover_*, *_pulse out
module ui_click_ctrl import ui_pkg::*; #(
  parameter int          ROM_LAT  = 1,
  parameter logic [1:0]  BTN_CODE = ui_pkg::BTN_CODE,
  parameter int          H_RES    = 640,
  parameter int          V_RES    = 480
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [9:0]            mouse_x,
  input  logic [9:0]            mouse_y,
  input  logic                  mouse_left,
  input  logic                  game_over,
  output logic [HIT_ADDR_W-1:0] rom_addr,
  input  logic [1:0]            menu_rom_data,
  input  logic [1:0]            over_rom_data,
  output logic [1:0]            screen,
  output logic                  hover_start,
  output logic                  hover_return,
  output logic                  start_pulse,
  output logic                  return_pulse
);
  localparam logic [10:0] HR = 11'(H_RES);
  localparam logic [10:0] VR = 11'(V_RES);
  screen_e scr_q, scr_d;
  lk_state_e st_q, st_d;
  logic [1:0] cnt_q, cnt_d, sel;
  logic [HIT_ADDR_W-1:0] addr_q, addr_d;
  logic in_q, in_d, in_rng, hit, chg, hs_q, hs_d, hr_q, hr_d;
  always_comb begin
    scr_d = (scr_q == SCR_MENU && start_pulse) ? SCR_GAME :
            (scr_q == SCR_GAME && game_over)   ? SCR_OVER :
            (scr_q == SCR_OVER && return_pulse) ? SCR_MENU : scr_q;
    chg = scr_d != scr_q;
    in_rng = ({1'b0, mouse_x} < HR) && ({1'b0, mouse_y} < VR);
    sel = scr_q == SCR_MENU ? menu_rom_data : scr_q == SCR_OVER ? over_rom_data : 2'd0;
    hit = (sel == BTN_CODE) && in_q;
    st_d = chg ? LK_IDLE :
           st_q == LK_IDLE ? LK_WAIT :
           st_q == LK_WAIT ? (cnt_q == 2'd1 ? LK_CAPT : LK_WAIT) : LK_IDLE;
    cnt_d = st_q == LK_IDLE ? 2'(ROM_LAT) : cnt_q - 2'd1;
    addr_d = st_q != LK_IDLE ? addr_q : in_rng ? hit_addr(mouse_x[9:1], mouse_y[9:1]) : '0;
    in_d = st_q == LK_IDLE ? in_rng : in_q;
    hs_d = chg ? 1'b0 : (st_q == LK_CAPT && scr_q == SCR_MENU) ? hit : hs_q;
    hr_d = chg ? 1'b0 : (st_q == LK_CAPT && scr_q == SCR_OVER) ? hit : hr_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      scr_q  <= SCR_MENU;
      st_q   <= LK_IDLE;
      cnt_q  <= 2'd0;
      addr_q <= '0;
      in_q   <= 1'b0;
      hs_q   <= 1'b0;
      hr_q   <= 1'b0;
    end else begin
      scr_q  <= scr_d;
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      addr_q <= addr_d;
      in_q   <= in_d;
      hs_q   <= hs_d;
      hr_q   <= hr_d;
    end
  end
  click_qualifier u_cq (
    .clk          (clk),
    .rst          (rst),
    .mouse_left   (mouse_left),
    .hover        (hs_q | hr_q),
    .sel_over     (scr_q == SCR_OVER),
    .clr          (chg),
    .start_pulse  (start_pulse),
    .return_pulse (return_pulse)
  );
  assign rom_addr     = addr_q;
  assign screen       = scr_q;
  assign hover_start  = hs_q;
  assign hover_return = hr_q;
endmodule

// File: tb/tb_ui_click_ctrl.sv
// tb_ui_click_ctrl: scoreboard bench driving ROM_LAT=1 and ROM_LAT=2 instances with shared directed stimulus
module tb_ui_click_ctrl;
  logic clk = 1'b0, rst = 1'b1, ml = 1'b0, go = 1'b0;
  logic [9:0] mx = 10'd250, my = 10'd210;
  logic [16:0] a0, a1;
  logic [1:0] s0, s1, d0, d1, p1;
  logic hs0, hs1, hr0, hr1, sp0, sp1, rp0, rp1;
  logic [1:0][1:0] scr;
  logic [1:0] hs, hr, sp, rp;
  int ncmp = 0, nfail = 0;
  int q0[$], q1[$];
  logic [1:0] pend = 2'b00;
  logic [1:0][1:0] escr;
  assign scr = {s1, s0};
  assign hs = {hs1, hs0};
  assign hr = {hr1, hr0};
  assign sp = {sp1, sp0};
  assign rp = {rp1, rp0};
  always #5 clk = ~clk;
  ui_click_ctrl #(.ROM_LAT(1)) u0 (
    .clk(clk), .rst(rst), .mouse_x(mx), .mouse_y(my), .mouse_left(ml), .game_over(go),
    .rom_addr(a0), .menu_rom_data(d0), .over_rom_data(d0), .screen(s0),
    .hover_start(hs0), .hover_return(hr0), .start_pulse(sp0), .return_pulse(rp0)
  );
  ui_click_ctrl #(.ROM_LAT(2)) u1 (
    .clk(clk), .rst(rst), .mouse_x(mx), .mouse_y(my), .mouse_left(ml), .game_over(go),
    .rom_addr(a1), .menu_rom_data(d1), .over_rom_data(d1), .screen(s1),
    .hover_start(hs1), .hover_return(hr1), .start_pulse(sp1), .return_pulse(rp1)
  );
  function automatic logic [1:0] code(input logic [16:0] ad);
    int x, y;
    x = int'(ad) % 320;
    y = int'(ad) / 320;
    return (x >= 100 && x <= 139 && y >= 100 && y <= 119) ? 2'd2 : 2'd0;
  endfunction
  always @(posedge clk) d0 <= code(a0);
  always @(posedge clk) begin
    p1 <= code(a1);
    d1 <= p1;
  end
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    ncmp++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask
  task automatic wt(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic push(input int e);
    q0.push_back(e);
    q1.push_back(e);
  endtask
  initial forever begin
    logic [31:0] got;
    int e;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      if (pend[k]) begin
        pend[k] = 1'b0;
        chk($sformatf("screen_after_pulse_u%0d", k), 32'(scr[k]), 32'(escr[k]));
        chk($sformatf("hover_clear_after_pulse_u%0d", k), 32'({hs[k], hr[k]}), 0);
      end
      if (sp[k] | rp[k]) begin
        got = 32'({rp[k], sp[k]});
        if ((k == 0 ? q0.size() : q1.size()) == 0) begin
          ncmp++;
          nfail++;
          $display("FAIL unexpected_pulse_u%0d: got kind %0d expected none", k, got);
        end else begin
          if (k == 0) e = q0.pop_front();
          else e = q1.pop_front();
          chk($sformatf("pulse_kind_u%0d", k), got, 32'(e));
          pend[k] = 1'b1;
          escr[k] = (e == 1) ? 2'd1 : 2'd0;
        end
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    nfail++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $fatal(1, "timeout");
  end
  initial begin
    int n[2];
    int last[2], nch[2];
    logic bad[2];
    logic [16:0] prv[2];
    logic [1:0][16:0] aa;
    logic any;
    wt(3);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst_screen_u%0d", k), 32'(scr[k]), 0);
      chk($sformatf("rst_outs_u%0d", k), 32'({hs[k], hr[k], sp[k], rp[k]}), 0);
    end
    chk("rst_addr", {15'd0, a1}, 0);
    chk("rst_addr_u0", {15'd0, a0}, 0);
    rst = 1'b0;
    n[0] = -1;
    n[1] = -1;
    for (int i = 1; i <= 8; i++) begin
      wt(1);
      for (int k = 0; k < 2; k++) if (hs[k] && n[k] < 0) n[k] = i;
    end
    chk("hover_start_latency_u0_ok", 32'(n[0] >= 1 && n[0] <= 4), 1);
    chk("hover_start_latency_u1_ok", 32'(n[1] >= 1 && n[1] <= 5), 1);
    mx = 10'd639; my = 10'd479;
    wt(6);
    chk("addr_max_u0", 32'(a0), 76799);
    chk("addr_max_u1", 32'(a1), 76799);
    chk("hover_max", 32'(hs), 0);
    mx = 10'd640; my = 10'd10;
    wt(6);
    chk("addr_x_oor_u0", 32'(a0), 0);
    chk("addr_x_oor_u1", 32'(a1), 0);
    mx = 10'd900; my = 10'd210;
    wt(6);
    chk("addr_x900_u0", 32'(a0), 0);
    chk("addr_x900_u1", 32'(a1), 0);
    chk("hover_x900_forced_nohit", 32'(hs), 0);
    my = 10'd10;
    wt(1);
    for (int k = 0; k < 2; k++) begin
      last[k] = -1; nch[k] = 0; bad[k] = 1'b0;
    end
    prv[0] = a0; prv[1] = a1;
    for (int i = 0; i < 30; i++) begin
      mx = 10'(100 + 2 * i);
      wt(1);
      aa = {a1, a0};
      for (int k = 0; k < 2; k++) if (aa[k] !== prv[k]) begin
        if (last[k] >= 0 && i - last[k] != k + 3) bad[k] = 1'b1;
        last[k] = i;
        nch[k]++;
        prv[k] = aa[k];
      end
    end
    chk("addr_hold_u0", 32'(bad[0]), 0);
    chk("addr_hold_u1", 32'(bad[1]), 0);
    chk("addr_changes_u0", 32'(nch[0] >= 8), 1);
    chk("addr_changes_u1", 32'(nch[1] >= 6), 1);
    mx = 10'd250; my = 10'd210;
    wt(8);
    chk("hover_on_button", 32'(hs), 3);
    ml = 1'b1; wt(2);
    mx = 10'd10; my = 10'd10; wt(10);
    ml = 1'b0; wt(5);
    chk("dragoff_screen", 32'(scr), 0);
    ml = 1'b1; wt(3);
    mx = 10'd250; my = 10'd210; wt(10);
    ml = 1'b0; wt(5);
    chk("dragon_screen", 32'(scr), 0);
    ml = 1'b1; wt(20);
    push(1);
    ml = 1'b0; wt(5);
    chk("start_screen_game", 32'(scr), 32'({2'd1, 2'd1}));
    wt(8);
    chk("game_hover_none", 32'({hs, hr}), 0);
    go = 1'b1; wt(1); go = 1'b0; wt(1);
    chk("game_over_screen", 32'(scr), 32'({2'd2, 2'd2}));
    wt(8);
    chk("hover_return_on", 32'({hs, hr}), 3);
    ml = 1'b1; wt(5);
    push(2);
    ml = 1'b0; wt(5);
    chk("return_screen_menu", 32'(scr), 0);
    go = 1'b1; wt(1); go = 1'b0; wt(3);
    chk("game_over_ignored_in_menu", 32'(scr), 0);
    wt(8);
    chk("hover_before_rst", 32'(hs), 3);
    mx = 10'd10; my = 10'd10;
    rst = 1'b1; wt(1); rst = 1'b0;
    any = 1'b0;
    for (int i = 0; i < 8; i++) begin
      wt(1);
      any |= |hs;
    end
    chk("no_stale_hover_after_rst", 32'(any), 0);
    wt(3);
    chk("sb_empty", 32'(q0.size() + q1.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
